// File: rtl/nes_pad_sampler.sv
// NES serial gamepad poller: drives latch/pad_clk, shifts in eight buttons, publishes active-high state.
// Optional PAD_DEBOUNCE_EN: publish a new button state only after two agreeing polls.
module nes_pad_sampler #(
  parameter int LATCH_CYCLES = 300,
  parameter int HALF_CYCLES  = 150,
  parameter int POLL_CYCLES  = 419_580
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       data,
  output logic       latch,
  output logic       pad_clk,
  output logic [7:0] buttons,
  output logic [7:0] pressed,
  output logic       valid
);

  localparam int POLL_W  = ($clog2(POLL_CYCLES)  < 1) ? 1 : $clog2(POLL_CYCLES);
  localparam int LATCH_W = ($clog2(LATCH_CYCLES) < 1) ? 1 : $clog2(LATCH_CYCLES);
  localparam int HALF_W  = ($clog2(HALF_CYCLES)  < 1) ? 1 : $clog2(HALF_CYCLES);

  localparam logic [POLL_W-1:0]  POLL_LAST  = POLL_W'(POLL_CYCLES - 1);
  localparam logic [LATCH_W-1:0] LATCH_LAST = LATCH_W'(LATCH_CYCLES - 1);
  localparam logic [HALF_W-1:0]  HALF_LAST  = HALF_W'(HALF_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LATCH,
    S_READ_LO,
    S_READ_HI,
    S_PUBLISH
  } state_t;

  state_t              r_state;
  state_t              w_next_state;
  logic                r_sync_0;
  logic                r_sync_1;
  logic [POLL_W-1:0]   r_poll_cnt;
  logic [LATCH_W-1:0]  r_latch_cnt;
  logic [HALF_W-1:0]   r_half_cnt;
  logic [2:0]          r_bit_idx;
  logic [7:0]          r_shift;
  logic                w_poll_wrap;
  logic                w_latch_done;
  logic                w_half_done;
  logic [7:0]          w_raw;
  logic [7:0]          w_new_buttons;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync_0 <= 1'b1;
      r_sync_1 <= 1'b1;
    end else begin
      r_sync_0 <= data;
      r_sync_1 <= r_sync_0;
    end
  end

  assign w_poll_wrap  = (r_poll_cnt == POLL_LAST);
  assign w_latch_done = (r_latch_cnt == LATCH_LAST);
  assign w_half_done  = (r_half_cnt == HALF_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_poll_cnt <= '0;
    end else if (w_poll_wrap) begin
      r_poll_cnt <= '0;
    end else begin
      r_poll_cnt <= r_poll_cnt + POLL_W'(1);
    end
  end

  // NOTE: every variable gets a default first so no path through the case leaves it unassigned (no latch).
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:    if (w_poll_wrap)  w_next_state = S_LATCH;
      S_LATCH:   if (w_latch_done) w_next_state = S_READ_LO;
      S_READ_LO: if (w_half_done)  w_next_state = S_READ_HI;
      S_READ_HI: if (w_half_done)  w_next_state = (r_bit_idx == 3'd7) ? S_PUBLISH : S_READ_LO;
      S_PUBLISH: w_next_state = S_IDLE;
      default:   w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_latch_cnt <= '0;
      r_half_cnt  <= '0;
      r_bit_idx   <= '0;
      r_shift     <= '0;
    end else begin
      r_latch_cnt <= (r_state == S_LATCH && !w_latch_done) ? r_latch_cnt + LATCH_W'(1) : '0;
      if ((r_state == S_READ_LO || r_state == S_READ_HI) && !w_half_done) begin
        r_half_cnt <= r_half_cnt + HALF_W'(1);
      end else begin
        r_half_cnt <= '0;
      end
      if (r_state == S_LATCH) begin
        r_bit_idx <= '0;
      end else if (r_state == S_READ_HI && w_half_done) begin
        r_bit_idx <= r_bit_idx + 3'd1;
      end
      // Slot 0 (button A) lands in bit 7, so the vector reads A..Right from MSB down.
      if (r_state == S_READ_LO && w_half_done) begin
        r_shift[3'd7 - r_bit_idx] <= r_sync_1;
      end
    end
  end

  assign w_raw = ~r_shift;

`ifdef PAD_DEBOUNCE_EN
  logic [7:0] r_prev_raw;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prev_raw <= '0;
    end else if (w_next_state == S_PUBLISH) begin
      r_prev_raw <= w_raw;
    end
  end

  assign w_new_buttons = (w_raw == r_prev_raw) ? w_raw : buttons;
`else
  assign w_new_buttons = w_raw;
`endif

  // Outputs are decoded from the next state so they are registered yet aligned with the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      latch   <= 1'b0;
      pad_clk <= 1'b1;
      valid   <= 1'b0;
      buttons <= '0;
      pressed <= '0;
    end else begin
      latch   <= (w_next_state == S_LATCH);
      pad_clk <= (w_next_state != S_READ_LO);
      valid   <= (w_next_state == S_PUBLISH);
      if (w_next_state == S_PUBLISH) begin
        buttons <= w_new_buttons;
        pressed <= w_new_buttons & ~buttons;
      end else begin
        pressed <= '0;
      end
    end
  end

endmodule

// File: doc/nes_pad_sampler.md
# nes_pad_sampler

Polls one NES-style serial gamepad and publishes a registered, active-high 8-button vector plus one-cycle press-edge pulses once per poll. It drives the pad's latch and clock pins, shifts in the eight serial bits and synchronises the pad data line. One instance per player sits between the pad pins and the movement and attack FSMs, all in the pixel-clock domain.

## Interface
Parameters:
- `LATCH_CYCLES`, default 300 — latch high width in clk cycles (≈12 µs at 25.175 MHz).
- `HALF_CYCLES`, default 150 — width of each pad_clk low or high half-period (≈6 µs).
- `POLL_CYCLES`, default 419_580 — poll period in clk cycles (≈60 Hz). Must satisfy POLL_CYCLES > LATCH_CYCLES + 16·HALF_CYCLES + 4.

Ports:
- `clk` in 1 — pixel clock; the only clock.
- `rst_n` in 1 — reset, asynchronous, active-low.
- `data` in 1 — pad serial data, active-low (0 = pressed), asynchronous to clk.
- `latch` out 1 — pad latch strobe.
- `pad_clk` out 1 — pad shift clock; idles high.
- `buttons` out 8 — debounced state, 1 = pressed. Bit order [7:0] = A, B, Select, Start, Up, Down, Left, Right.
- `pressed` out 8 — one-cycle pulse per bit on a 0→1 transition of `buttons`.
- `valid` out 1 — one-cycle pulse when a poll completes.

## Operation
- `data` passes through a 2-flop synchroniser; only the synchronised value is sampled.
- Free-running poll counter, 0..POLL_CYCLES-1, wraps to 0. Reset value 0.
- FSM states:
  - IDLE: latch=0, pad_clk=1. Goes to LATCH on the cycle the counter equals POLL_CYCLES-1.
  - LATCH: latch=1 for exactly LATCH_CYCLES cycles, then READ_LO with bit_idx=0.
  - READ_LO: pad_clk=0 for HALF_CYCLES cycles. On the last cycle, the synchronised data is stored at shift bit 7-bit_idx. Then READ_HI.
  - READ_HI: pad_clk=1 for HALF_CYCLES cycles. Then READ_LO with bit_idx+1; if bit_idx==7, go to PUBLISH instead.
  - PUBLISH: one cycle. Asserts valid, updates buttons and pressed, returns to IDLE.
- Eight full pad_clk pulses are generated; the 8th rising edge is harmless to the pad.
- Published value is raw = ~shift (inversion to active-high).
- pressed = new_buttons & ~old_buttons, issued in the same cycle as valid; 0 in every other cycle.
- Half-period and latch counters are sized by $clog2 of their parameter. bit_idx is 3 bits.
- Reset mid-poll: asynchronously returns to IDLE. Counters, shift register, buttons and pressed are all cleared. The next poll starts a full POLL_CYCLES later.

## Timing
- Reset values: latch=0, pad_clk=1, buttons=8'h00, pressed=8'h00, valid=0, state=IDLE.
- All outputs are registered; no combinational path from data to any output.
- Let P be the cycle in which the counter equals POLL_CYCLES-1. Then:
  - latch is high from P+1 through P+LATCH_CYCLES.
  - The bit-k low phase starts at P+1+LATCH_CYCLES+2k·HALF_CYCLES.
  - valid pulses at P+1+LATCH_CYCLES+16·HALF_CYCLES. buttons updates in that same cycle.
- Data sampling requirement: a data level held stable from its low-phase start is captured. The synchroniser adds 2 cycles, and HALF_CYCLES ≥ 3 is required.
- Successive valid pulses are exactly POLL_CYCLES apart.

## Configuration
- `PAD_DEBOUNCE_EN` defined: the previous raw sample is kept. buttons updates only when the current raw equals the previous raw; otherwise buttons holds and pressed=0. valid still pulses every poll. A change therefore appears after two agreeing polls.
- Not defined: buttons = raw on every poll; no previous-raw register is built.

## Test plan
Parameters for the bench: LATCH_CYCLES=4, HALF_CYCLES=3, POLL_CYCLES=100.
- After reset, `latch` rises at cycle 100, is 4 cycles wide, and is followed by 8 pad_clk low/high pulses of 3+3 cycles; valid pulses at cycle 152 and again at 252.
- Pad model drives A and Left (data low in bit slots 0 and 6) → buttons=8'b1000_0010 and pressed=8'b1000_0010 with valid. The next identical poll gives pressed=0.
- Bits change from A to B → buttons=8'b0100_0000, pressed=8'b0100_0000; the release of A gives no pulse.
- Assert rst_n low for 1 cycle mid-READ (bit 3) → latch=0, pad_clk=1, buttons=0 immediately; the next valid comes 100+52 cycles after reset release.
- With `PAD_DEBOUNCE_EN`, a single-poll glitch of Start (8'h10) → buttons stays 8'h00. Start held for 2 polls → buttons=8'h10 on the second valid.
- data toggling asynchronously during LATCH only → no effect on the sampled bits.
